// File: rtl/reg_mux_pkg.sv
// Shared constants for the register-bank write-back selector: default
// datapath width, load-size encodings and source-select encodings.
package reg_mux_pkg;

    localparam int DATA_W_DEF = 32;

    // Load size encodings; 2'b11 behaves like a full word load.
    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    // Write-back source select encodings.
    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_RAM = 1'b1;

endpackage

// File: rtl/reg_mux_load_fmt.sv
// Combinational load formatter: picks the byte or halfword lane addressed
// by addrLo out of the RAM word and sign- or zero-extends it to 32 bits.
// Misaligned halfword offsets are not trapped; addrLo[0] is simply ignored.
module reg_mux_load_fmt
    import reg_mux_pkg::*;
(
    input  logic [31:0] ramData,
    input  logic [1:0]  ldSize,
    input  logic        ldSigned,
    input  logic [1:0]  addrLo,
    output logic [31:0] loadWord
);

    logic [7:0]  byteField;
    logic [15:0] halfField;

    // Select the addressed byte lane (lane 0 = bits 7:0).
    always_comb begin
        byteField = ramData[7:0];
        case (addrLo)
            2'd1:    byteField = ramData[15:8];
            2'd2:    byteField = ramData[23:16];
            2'd3:    byteField = ramData[31:24];
            default: byteField = ramData[7:0];
        endcase
    end

    // Select the addressed halfword; only the upper offset bit matters.
    always_comb begin
        halfField = addrLo[1] ? ramData[31:16] : ramData[15:0];
    end

    // Extend the selected field, or pass the word through untouched.
    always_comb begin
        loadWord = ramData;
        case (ldSize)
            LD_BYTE: loadWord = {{24{ldSigned & byteField[7]}}, byteField};
            LD_HALF: loadWord = {{16{ldSigned & halfField[15]}}, halfField};
            default: loadWord = ramData;
        endcase
    end

endmodule

// File: rtl/reg_mux.sv
// Write-back source selector: registers either the data-memory word or the
// ALU result (chosen by EN) and presents it to the register-bank write port.
// dataOut comes straight from a flop, so there is no input-to-output path.
// Optional feature macro REG_MUX_LOAD_EXT_EN adds byte/halfword load
// formatting on the RAM path; with it DATA_W must stay at 32.
module reg_mux
    import reg_mux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EN,
    input  logic [DATA_W-1:0] ramData,
    input  logic [DATA_W-1:0] ALUresult,
`ifdef REG_MUX_LOAD_EXT_EN
    input  logic [1:0]        ldSize,
    input  logic              ldSigned,
    input  logic [1:0]        addrLo,
`endif
    output logic [DATA_W-1:0] dataOut
);

    logic [DATA_W-1:0] memWord;
    logic [DATA_W-1:0] nextWord;

`ifdef REG_MUX_LOAD_EXT_EN
    // The formatter is fixed at 32 bits, matching the only legal width here.
    reg_mux_load_fmt uLoadFmt (
        .ramData  (ramData),
        .ldSize   (ldSize),
        .ldSigned (ldSigned),
        .addrLo   (addrLo),
        .loadWord (memWord)
    );
`else
    // Without load formatting the RAM word is written back whole.
    assign memWord = ramData;
`endif

    // Pick the write-back source for the next edge.
    always_comb begin
        nextWord = (EN == SEL_RAM) ? memWord : ALUresult;
    end

    // Output register; reset clears it immediately and drops any pending value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataOut <= '0;
        end else begin
            dataOut <= nextWord;
        end
    end

endmodule

// File: tb/tb_reg_mux.sv
// Bench for reg_mux: reset behaviour, table-driven select vectors, hold and
// asynchronous reset sequences, and randomized traffic against a reference.
module tb_reg_mux;
    import reg_mux_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] ram;
    logic [31:0] alu;
    logic [31:0] dataOut;
`ifdef REG_MUX_LOAD_EXT_EN
    logic [1:0]  ldSize;
    logic        ldSigned;
    logic [1:0]  addrLo;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Clock / reset block: 10 ns clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    reg_mux #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EN        (en),
        .ramData   (ram),
        .ALUresult (alu),
`ifdef REG_MUX_LOAD_EXT_EN
        .ldSize    (ldSize),
        .ldSigned  (ldSigned),
        .addrLo    (addrLo),
`endif
        .dataOut   (dataOut)
    );

    typedef struct {
        string       name;
        logic        en;
        logic [31:0] ram;
        logic [31:0] alu;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: dataOut=%08h expected=%08h", name, act, exp);
        end
    endtask

    // Driver: change stimulus on the falling edge, well away from the active edge.
    task automatic drive(input logic e, input logic [31:0] r, input logic [31:0] a);
        @(negedge clk);
        en  = e;
        ram = r;
        alu = a;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

`ifdef REG_MUX_LOAD_EXT_EN
    // Reference load formatting built from shifts, masks and the
    // xor/subtract sign-extension identity.
    function automatic logic [31:0] load_model(input logic [31:0] r, input logic [1:0] sz,
                                               input logic sg, input logic [1:0] ad);
        logic [31:0] f;
        if (sz == 2'd0) begin
            f = (r >> (8 * ad)) & 32'h0000_00FF;
            return sg ? (f ^ 32'h80) - 32'h80 : f;
        end else if (sz == 2'd1) begin
            f = (r >> (16 * ad[1])) & 32'h0000_FFFF;
            return sg ? (f ^ 32'h8000) - 32'h8000 : f;
        end
        return r;
    endfunction

    typedef struct {
        string       name;
        logic        en;
        logic [1:0]  sz;
        logic        sg;
        logic [1:0]  ad;
        logic [31:0] alu;
        logic [31:0] exp;
    } fmt_vec_t;
`endif

    initial begin
        vec_t vecs[$];
`ifdef REG_MUX_LOAD_EXT_EN
        fmt_vec_t fvecs[$];
        ldSize   = LD_WORD;
        ldSigned = 1'b0;
        addrLo   = 2'd0;
`endif

        // Reset held with RAM path selected and all-ones data.
        rst_n = 1'b0;
        en    = 1'b1;
        ram   = 32'hFFFF_FFFF;
        alu   = 32'h0;
        #1;
        check("reset_immediate", dataOut, 32'h0);
        for (int i = 0; i < 3; i++) begin
            after_edge();
            check("reset_held", dataOut, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        after_edge();
        check("reset_release_load", dataOut, 32'hFFFF_FFFF);

        // Select toggle plus a few other data patterns.
        vecs.push_back('{"toggle_ram_a", 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF});
        vecs.push_back('{"toggle_ram_b", 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF});
        vecs.push_back('{"toggle_alu_a", 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000});
        vecs.push_back('{"toggle_alu_b", 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000});
        vecs.push_back('{"toggle_ram_c", 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF});
        vecs.push_back('{"toggle_ram_d", 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF});
        vecs.push_back('{"toggle_alu_c", 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000});
        vecs.push_back('{"toggle_alu_d", 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000});
        vecs.push_back('{"pattern_ram", 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hA5A5_A5A5});
        vecs.push_back('{"pattern_alu", 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h5A5A_5A5A});
        vecs.push_back('{"alu_value", 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678});
        vecs.push_back('{"ram_value", 1'b1, 32'h8000_0001, 32'h1234_5678, 32'h8000_0001});
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].ram, vecs[i].alu);
            after_edge();
            check(vecs[i].name, dataOut, vecs[i].exp);
        end

        // Hold between edges: a mid-cycle ALU change must wait for the next edge.
        drive(1'b0, 32'hFFFF_FFFF, 32'h0);
        after_edge();
        check("hold_before", dataOut, 32'h0);
        #2;
        alu = 32'h1234_5678;
        #1;
        check("hold_mid_cycle", dataOut, 32'h0);
        after_edge();
        check("hold_next_edge", dataOut, 32'h1234_5678);

        // Asynchronous reset between edges while dataOut is all ones.
        drive(1'b1, 32'hFFFF_FFFF, 32'h0);
        after_edge();
        check("async_pre", dataOut, 32'hFFFF_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_no_edge", dataOut, 32'h0);
        after_edge();
        check("async_held_edge", dataOut, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        alu   = 32'hCAFE_F00D;
        after_edge();
        check("async_release_load", dataOut, 32'hCAFE_F00D);

`ifdef REG_MUX_LOAD_EXT_EN
        // Load formatting vectors on ramData = 80FF7F01.
        fvecs.push_back('{"byte_a3_signed",   1'b1, LD_BYTE, 1'b1, 2'd3, 32'h0, 32'hFFFF_FF80});
        fvecs.push_back('{"byte_a1_unsigned", 1'b1, LD_BYTE, 1'b0, 2'd1, 32'h0, 32'h0000_007F});
        fvecs.push_back('{"byte_a2_signed",   1'b1, LD_BYTE, 1'b1, 2'd2, 32'h0, 32'hFFFF_FFFF});
        fvecs.push_back('{"half_a2_signed",   1'b1, LD_HALF, 1'b1, 2'd2, 32'h0, 32'hFFFF_80FF});
        fvecs.push_back('{"half_a0_signed",   1'b1, LD_HALF, 1'b1, 2'd0, 32'h0, 32'h0000_7F01});
        fvecs.push_back('{"half_a3_unsigned", 1'b1, LD_HALF, 1'b0, 2'd3, 32'h0, 32'h0000_80FF});
        fvecs.push_back('{"word_load",        1'b1, LD_WORD, 1'b1, 2'd3, 32'h0, 32'h80FF_7F01});
        fvecs.push_back('{"alu_ignores_fmt",  1'b0, LD_BYTE, 1'b1, 2'd3, 32'h11, 32'h0000_0011});
        foreach (fvecs[i]) begin
            drive(fvecs[i].en, 32'h80FF_7F01, fvecs[i].alu);
            ldSize   = fvecs[i].sz;
            ldSigned = fvecs[i].sg;
            addrLo   = fvecs[i].ad;
            after_edge();
            check(fvecs[i].name, dataOut, fvecs[i].exp);
        end
`endif

        // Randomized traffic through the scoreboard queue.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom(), $urandom());
`ifdef REG_MUX_LOAD_EXT_EN
            ldSize   = 2'($urandom_range(0, 3));
            ldSigned = 1'($urandom_range(0, 1));
            addrLo   = 2'($urandom_range(0, 3));
            exp_q.push_back(en ? load_model(ram, ldSize, ldSigned, addrLo) : alu);
`else
            exp_q.push_back(en ? ram : alu);
`endif
            after_edge();
            check("random", dataOut, exp_q.pop_front());
        end

        // Final report.
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
